multi_cycle_cpu: RTL and testbench
==================================

# multi_cycle_cpu

Multi-cycle MIPS-subset processor that replaces the single-cycle datapath with a state-machine-sequenced datapath. One ALU and one unified memory port are shared across cycles. The memory port has a req/ready handshake, so slow or wait-stated memories stall the core cleanly. It is the top-level CPU of the next design generation, with a parametrised reset vector and address width, a real PC with branch/jump, and halt-on-illegal.

## Interface
Parameters:
- ADDR_W, 32: byte-address width of `pc` and `mem_addr`, legal range 8..32; PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while `mem_req`=1.
- mem_addr  output  ADDR_W  word-aligned byte address.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data; valid in the cycle `mem_ready`=1.
- mem_ready  input  1  access completes in any cycle where `mem_req` & `mem_ready`.
- pc  output  ADDR_W  current PC.
- inst  output  32  instruction register (IR).
- state  output  3  FSM state encoding.
- halted  output  1  core stopped.
- illegal  output  1  halt was caused by an unsupported opcode/funct.

## Operation
- ISA:
  - R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, addi 0x08 (sign-extended immediate), beq 0x04, j 0x02.
  - No overflow traps; arithmetic is 32-bit two's-complement, carry discarded.
- Register file: 32 x 32. Reads of r0 return 0; writes to r0 are dropped. Writeback uses rd for R-type and rt for lw/addi.
- FSM states:
  - FETCH (0): `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. On ready: IR <= `mem_rdata`, `pc` <= `pc`+4, go to DECODE.
  - DECODE (1): latch A=R[rs], B=R[rt]. ALUOut <= `pc` + (sext(imm)<<2) as the branch target.
    - j: `pc` <= {`pc`[ADDR_W-1:28], IR[25:0], 2'b00}, truncated to ADDR_W; go to FETCH.
    - Unsupported opcode/funct: go to HALT with `illegal`=1.
    - Otherwise go to EXEC.
  - EXEC (2):
    - R-type/addi/lw/sw: ALUOut <= result.
    - beq: if A==B then `pc` <= ALUOut; go to FETCH.
    - R-type/addi go to WB; lw/sw go to MEM.
  - MEM (3): `mem_req`=1, `mem_addr`=ALUOut[ADDR_W-1:0] with bits [1:0] forced to 0.
    - sw: `mem_we`=1, `mem_wdata`=B; on ready go to FETCH.
    - lw: on ready MDR <= `mem_rdata`, go to WB.
  - WB (4): write ALUOut or MDR to the register file; go to FETCH.
  - HALT (5): `halted`=1, no further requests; left only by `rst`.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from assertion until the ready cycle. `mem_ready` is ignored whenever `mem_req`=0.

## Timing
- Reset values:
  - `pc`=RESET_PC, `inst`=0, `state`=FETCH.
  - `mem_req` is driven by the FETCH state, so `mem_req`=1 from the first cycle after reset.
  - `mem_we`=0, `halted`=0, `illegal`=0. Register contents and `mem_wdata` are 0 after reset.
- Zero-wait cycle counts (`mem_ready` tied high): R-type/addi 4, lw 5, sw 4, beq 3, j 2. Each wait cycle on an access adds one cycle.
- Ready may assert in the same cycle `mem_req` rises (zero wait).
- `rst` during any state, including a pending access, wins: `mem_req`=0 for exactly one cycle, then FETCH at RESET_PC.
- The register write in WB and the operand read in the next DECODE are at least 2 cycles apart, so no bypass is needed.
- PC at 2^ADDR_W-4 wraps to 0 after fetch.

## Configuration
- `MCPU_BNE_EN`
  - Defined: opcode 0x05 (bne) is decoded. It behaves like beq with inverted compare and takes 3 cycles.
  - Undefined: opcode 0x05 is illegal and sends the core to HALT with `illegal`=1.

## Test plan
- **Reset/fetch:** RESET_PC=0x40, zero-wait memory. After `rst` falls, `mem_addr`=0x40 and `mem_req`=1; after a nop (0x00000020, add r0,r0,r0), `pc`=0x44 within 4 cycles.
- **ALU/writeback:**
  - Program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sub r5,r2,r1.
  - Expected: r3=2, r4=1, r5=0xFFFFFFF8. Writes to r0 leave it reading 0.
- **Load/store with waits:**
  - Memory inserts 3 wait states on every access. Run sw r1,8(r0) then lw r6,8(r0).
  - Expected: `mem_we`=1 at addr 8 with `mem_wdata`=5, address/data held through all 3 wait cycles, r6=5; the lw takes 5+3+3=11 cycles.
- **Branch/jump:**
  - beq with equal operands and imm=-1 loops on itself (`pc` revisits the same address).
  - beq with unequal operands falls through to `pc`+4.
  - j 0x000010 sets `pc`=0x40.
- **Illegal/halt:**
  - Opcode 0x3F: `halted`=1 and `illegal`=1; no `mem_req` for 20 cycles.
  - Opcode 0x05 behaves the same without `MCPU_BNE_EN`; with the macro defined, bne executes as a branch.
- **Reset mid-access:** assert `rst` during a lw MEM wait. `mem_req`=0 the next cycle, then FETCH at RESET_PC, and the destination register is unchanged.

Source files
------------

// File: rtl/multi_cycle_cpu_if.sv
// multi_cycle_cpu_if: unified memory port with req/ready handshake
interface multi_cycle_cpu_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: FSM-sequenced MIPS subset core on one shared memory port (MCPU_BNE_EN adds bne)
module multi_cycle_cpu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_cycle_cpu_if.master        bus,
    output logic [ADDR_W-1:0]        pc,
    output logic [31:0]              inst,
    output logic [2:0]               state,
    output logic                     halted,
    output logic                     illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    state_t      st;
    logic [31:0] rf [32];
    logic [31:0] a, b, alu_out, mdr;

    logic [5:0]        op, fn;
    logic [4:0]        rs, rt, rd, wd;
    logic [31:0]       imm, pc_ext, jt, br_t, alu_res, wv;
    logic              is_r, r_ok, is_bne, legal, take;
    logic [ADDR_W-1:0] pc4, br_pc;

    assign state  = st;
    assign op     = inst[31:26];
    assign fn     = inst[5:0];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign imm    = {{16{inst[15]}}, inst[15:0]};
    assign is_r   = op == OP_R;
    assign r_ok   = fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
`ifdef MCPU_BNE_EN
    assign is_bne = op == OP_BNE;
`else
    assign is_bne = 1'b0;
`endif
    assign legal  = (is_r && r_ok) || op == OP_LW || op == OP_SW || op == OP_ADDI
                    || op == OP_BEQ || op == OP_J || is_bne;
    assign pc4    = pc + ADDR_W'(4);
    assign pc_ext = 32'(pc);
    assign jt     = (pc_ext & 32'hF000_0000) | {4'b0, inst[25:0], 2'b00};
    assign br_t   = pc_ext + (imm << 2);
    assign take   = is_bne ? a != b : a == b;
    assign br_pc  = take ? ADDR_W'(alu_out) : pc;
    assign alu_res = !is_r         ? a + imm :
                     fn == FN_SUB  ? a - b :
                     fn == FN_AND  ? a & b :
                     fn == FN_OR   ? a | b :
                     fn == FN_SLT  ? {31'b0, $signed(a) < $signed(b)} : a + b;
    assign wd     = is_r ? rd : rt;
    assign wv     = op == OP_LW ? mdr : alu_out;

    // Control FSM, datapath registers and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= RESET_PC;
            bus.wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (st)
                FETCH: begin
                    if (!bus.req) begin
                        bus.req  <= 1'b1;
                        bus.addr <= pc;
                    end else if (bus.ready) begin
                        inst    <= bus.rdata;
                        pc      <= pc4;
                        bus.req <= 1'b0;
                        st      <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= br_t;
                    if (!legal) begin
                        st      <= HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else if (op == OP_J) begin
                        pc       <= ADDR_W'(jt);
                        bus.req  <= 1'b1;
                        bus.addr <= ADDR_W'(jt);
                        st       <= FETCH;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    if (op == OP_BEQ || is_bne) begin
                        pc       <= br_pc;
                        bus.req  <= 1'b1;
                        bus.addr <= br_pc;
                        st       <= FETCH;
                    end else begin
                        alu_out <= alu_res;
                        if (op == OP_LW || op == OP_SW) begin
                            bus.req   <= 1'b1;
                            bus.we    <= op == OP_SW;
                            bus.addr  <= ADDR_W'({alu_res[31:2], 2'b00});
                            bus.wdata <= b;
                            st        <= MEM;
                        end else begin
                            st <= WB;
                        end
                    end
                end
                MEM: begin
                    if (bus.ready) begin
                        mdr    <= bus.rdata;
                        bus.we <= 1'b0;
                        if (op == OP_SW) begin
                            bus.addr <= pc;
                            st       <= FETCH;
                        end else begin
                            bus.req <= 1'b0;
                            st      <= WB;
                        end
                    end
                end
                WB: begin
                    if (wd != 5'd0) rf[wd] <= wv;
                    bus.req  <= 1'b1;
                    bus.addr <= pc;
                    st       <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed programs with a store scoreboard and a handshake-hold monitor
module tb_multi_cycle_cpu;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] pc, inst;
    logic [2:0]  state;
    logic        halted, illegal;

    logic [31:0] m [256];
    logic [3:0]  cnt = 0, wait_st = 0;
    logic        clr = 0, ld_en = 0, rst_q = 1, pend = 0;
    logic [31:0] ld_a = 0, ld_d = 0;
    logic [65:0] held = 0;
    logic [63:0] sb [$];
    logic [31:0] prog [$];
    int          tests = 0, fails = 0;

    multi_cycle_cpu_if #(.ADDR_W(32)) bus ();

    multi_cycle_cpu #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pc(pc), .inst(inst),
        .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign bus.ready = bus.req && cnt == wait_st;
    assign bus.rdata = m[bus.addr[9:2]];

    // Memory with programmable wait states
    always @(posedge clk) begin
        if (clr) for (int i = 0; i < 256; i++) m[i] <= '0;
        else if (ld_en) m[ld_a[9:2]] <= ld_d;
        else if (!rst && bus.req && bus.we && bus.ready) m[bus.addr[9:2]] <= bus.wdata;
        cnt   <= (rst || !bus.req || bus.ready) ? 4'd0 : cnt + 4'd1;
        rst_q <= rst;
    end

    // Monitor: store scoreboard plus request hold across wait cycles
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.req && bus.we && bus.ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL store_unexpected: got addr=%h data=%h, required no store", bus.addr, bus.wdata);
            end else begin
                e = sb.pop_front();
                if ({bus.addr, bus.wdata} !== e) begin
                    fails++;
                    $display("FAIL store: got addr=%h data=%h, required addr=%h data=%h",
                             bus.addr, bus.wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (pend && !rst_q) begin
            tests++;
            if ({bus.req, bus.we, bus.addr, bus.wdata} !== held) begin
                fails++;
                $display("FAIL req_hold: got %h, required %h", {bus.req, bus.we, bus.addr, bus.wdata}, held);
            end
        end
        pend = bus.req && !bus.ready;
        held = {bus.req, bus.we, bus.addr, bus.wdata};
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic setup(input int w);
        rst = 1;
        wait_st = 4'(w);
        sb.delete();
        clr = 1;
        @(negedge clk);
        clr = 0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1;
        ld_a  = a;
        ld_d  = d;
        @(negedge clk);
        ld_en = 0;
    endtask

    task automatic load();
        foreach (prog[i]) put(32'h40 + 32'(i) * 4, prog[i]);
    endtask

    task automatic go();
        check("rst_pc", pc, 32'h40);
        check("rst_inst", inst, 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_req", 32'(bus.req), 32'h0);
        check("rst_we", 32'(bus.we), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        rst = 0;
    endtask

    task automatic wait_pc(input string nm, input logic [31:0] p, input int lim);
        int n = 0;
        while (pc !== p && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, pc, p);
    endtask

    task automatic wait_halt(input int lim);
        int n = 0;
        while (halted !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("halted", 32'(halted), 32'h1);
        check("illegal", 32'(illegal), 32'h1);
    endtask

    task automatic wait_sb(input string nm, input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset/fetch and ALU writeback, results observed through stores
        setup(0);
        prog = '{32'h00000020, 32'h20010005, 32'h2002FFFD, 32'h00221820, 32'h0041202A,
                 32'h00412822, 32'h00223824, 32'h00224025, 32'h20000007, 32'hAC030100,
                 32'hAC040104, 32'hAC050108, 32'hAC07010C, 32'hAC080110, 32'hAC000114,
                 32'hFC000000};
        load();
        sb.push_back({32'h100, 32'h2});
        sb.push_back({32'h104, 32'h1});
        sb.push_back({32'h108, 32'hFFFFFFF8});
        sb.push_back({32'h10C, 32'h5});
        sb.push_back({32'h110, 32'hFFFFFFFD});
        sb.push_back({32'h114, 32'h0});
        go();
        @(negedge clk);
        check("first_req", 32'(bus.req), 32'h1);
        check("first_addr", bus.addr, 32'h40);
        wait_pc("nop_pc", 32'h44, 4);
        wait_halt(300);
        wait_sb("alu_stores", 5);

        // Store then load with three wait states per access
        setup(3);
        put(32'h8, 32'hDEADBEEF);
        prog = '{32'h20010005, 32'hAC010008, 32'h8C060008, 32'hAC060118, 32'hFC000000};
        load();
        sb.push_back({32'h8, 32'h5});
        sb.push_back({32'h118, 32'h5});
        go();
        n = 0;
        while (!(state == 3'd0 && pc == 32'h48) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (!(state == 3'd0 && pc == 32'h4C) && n < 40);
        check("lw_cycles", 32'(n), 32'd11);
        wait_halt(200);
        wait_sb("ls_stores", 5);

        // beq not taken falls through, then j back to 0x40
        setup(0);
        prog = '{32'h20010001, 32'h10200001, 32'hAC010120, 32'h08000010};
        load();
        sb.push_back({32'h120, 32'h1});
        go();
        wait_sb("beq_fall_store", 40);
        wait_pc("pre_jump_pc", 32'h50, 20);
        wait_pc("j_target", 32'h40, 10);

        // beq with equal operands and imm=-1 spins in place
        setup(0);
        prog = '{32'h1000FFFF};
        load();
        go();
        wait_pc("loop_fetch", 32'h44, 10);
        wait_pc("loop_back", 32'h40, 10);
        wait_pc("loop_fetch2", 32'h44, 10);
        wait_pc("loop_back2", 32'h40, 10);

        // Unsupported opcode halts with no further requests
        setup(0);
        prog = '{32'hFC000000};
        load();
        go();
        wait_halt(20);
        check("halt_pc", pc, 32'h44);
        check("halt_state", 32'(state), 32'h5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req) n++;
        end
        check("halt_no_req", 32'(n), 32'h0);

        // Opcode 0x05: branch when bne is built in, otherwise illegal
        setup(0);
        prog = '{32'h20010001, 32'h14200001, 32'hAC010124, 32'hAC010128, 32'hFC000000};
        load();
`ifdef MCPU_BNE_EN
        sb.push_back({32'h128, 32'h1});
`endif
        go();
        wait_halt(100);
`ifdef MCPU_BNE_EN
        check("bne_halt_pc", pc, 32'h54);
`else
        check("bne_halt_pc", pc, 32'h48);
`endif
        wait_sb("bne_stores", 5);

        // Reset during a lw memory wait
        setup(3);
        put(32'h8, 32'h77);
        prog = '{32'h20060009, 32'h8C060008, 32'hFC000000};
        load();
        go();
        n = 0;
        while (!(state == 3'd3 && bus.req) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mem_wait_reached", 32'(state), 32'h3);
        rst = 1;
        @(negedge clk);
        check("rst_req_drop", 32'(bus.req), 32'h0);
        rst = 0;
        @(negedge clk);
        check("rst_refetch_req", 32'(bus.req), 32'h1);
        check("rst_refetch_addr", bus.addr, 32'h40);
        check("rst_refetch_state", 32'(state), 32'h0);
        setup(0);
        prog = '{32'hAC06012C, 32'hFC000000};
        load();
        sb.push_back({32'h12C, 32'h0});
        go();
        wait_halt(40);
        wait_sb("dest_unchanged", 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
